// File: rtl/chan_scan_mux.sv
// Registered N-channel, W-bit multiplexer: manual select, timed auto-scan
// over unmasked channels, and a hold mode that freezes the output.
module chan_scan_mux #(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    parameter int  DWELL    = 100,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      hz100,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       skip_mask,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          cur_ch,
    output logic                      ch_change,
    output logic                      all_masked
);

    localparam int                 CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]   DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W:0]     CH_LIMIT   = (SEL_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SCAN   = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] ch_data [CHANNELS];

    logic [WIDTH-1:0] out_reg, out_next;
    logic [SEL_W-1:0] cur_reg, cur_next;
    logic [SEL_W-1:0] scan_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ch_change_reg;
    logic             all_masked_reg, all_masked_next;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_slice
            assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_ff @(posedge hz100) begin
        if (reset) begin
            state_reg <= ST_MANUAL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = ST_HOLD;
        case (mode)
            2'b00:   state_next = ST_MANUAL;
            2'b01:   state_next = ST_SCAN;
            default: state_next = ST_HOLD;
        endcase
    end

    // Nearest unmasked channel above cur_reg, wrapping; smallest offset wins.
    always_comb begin : p_scan_next
        logic [SEL_W:0] wide;
        wide      = '0;
        scan_next = cur_reg;
        for (int off = CHANNELS - 1; off >= 1; off--) begin
            wide = {1'b0, cur_reg} + (SEL_W + 1)'(off);
            if (wide >= CH_LIMIT) begin
                wide = wide - CH_LIMIT;
            end
            if (!skip_mask[wide[SEL_W-1:0]]) begin
                scan_next = wide[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        cur_next        = cur_reg;
        cnt_next        = cnt_reg;
        out_next        = out_reg;
        all_masked_next = 1'b0;
        case (state_next)
            ST_MANUAL: begin
                out_next = ch_data[cur_reg];
                cnt_next = '0;
                if ({1'b0, sel} < CH_LIMIT) begin
                    cur_next = sel;
                end
            end
            ST_SCAN: begin
                out_next = ch_data[cur_reg];
                if (&skip_mask) begin
                    cnt_next        = '0;
                    all_masked_next = 1'b1;
                end else if (state_reg != ST_SCAN) begin
                    cnt_next = '0;
                end else if (skip_mask[cur_reg] || (cnt_reg == DWELL_LAST)) begin
                    cnt_next = '0;
                    cur_next = scan_next;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            out_reg        <= '0;
            cur_reg        <= '0;
            cnt_reg        <= '0;
            ch_change_reg  <= 1'b0;
            all_masked_reg <= 1'b0;
        end else begin
            out_reg        <= out_next;
            cur_reg        <= cur_next;
            cnt_reg        <= cnt_next;
            ch_change_reg  <= (cur_next != cur_reg);
            all_masked_reg <= all_masked_next;
        end
    end

    assign out        = out_reg;
    assign cur_ch     = cur_reg;
    assign ch_change  = ch_change_reg;
    assign all_masked = all_masked_reg;

endmodule
